// File: rtl/regfile_v2.sv
// Register file with trigger-set register, per-register busy (load pending) tracking and stall.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through on reads, taps and stall.
module regfile_v2 #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int TRIG_REG      = 5,
  parameter int A0_REG        = 10,
  parameter int RA_REG        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] A1,
  input  logic [ADDRESS_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  input  logic [ADDRESS_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic                     WE3,
  input  logic                     trigger,
  input  logic                     busy_set,
  input  logic [ADDRESS_WIDTH-1:0] busy_addr,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic [DATA_WIDTH-1:0]    ra
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] L_TRIG = ADDRESS_WIDTH'(TRIG_REG);
  localparam logic [ADDRESS_WIDTH-1:0] L_A0   = ADDRESS_WIDTH'(A0_REG);
  localparam logic [ADDRESS_WIDTH-1:0] L_RA   = ADDRESS_WIDTH'(RA_REG);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_trigPrev;

  logic w_trigEdge;
  logic w_wrEn;
  logic w_trigWr;
  logic w_busySet;

  assign w_trigEdge = r_sync2 & ~r_trigPrev;
  assign w_wrEn     = WE3 && (A3 != '0);
  assign w_trigWr   = w_trigEdge && (L_TRIG != '0);
  assign w_busySet  = busy_set && (busy_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_trigPrev <= 1'b0;
    end else begin
      r_sync1    <= trigger;
      r_sync2    <= r_sync1;
      r_trigPrev <= r_sync2;
    end
  end

  // The trigger write is placed last so it overrides a software write to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wrEn) begin
        r_regs[A3] <= WD3;
      end
      if (w_trigWr) begin
        r_regs[L_TRIG] <= DATA_WIDTH'(1);
      end
    end
  end

  // Set is placed after clear so a new load supersedes the completing one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_wrEn) begin
        r_busy[A3] <= 1'b0;
      end
      if (w_busySet) begin
        r_busy[busy_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    value = (addr == '0) ? '0 : r_regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wrEn && (addr == A3)) begin
      value = (w_trigWr && (A3 == L_TRIG)) ? DATA_WIDTH'(1) : WD3;
    end
`endif
    return value;
  endfunction

  function automatic logic busyOf(input logic [ADDRESS_WIDTH-1:0] addr);
    logic pending;
    pending = (addr == '0) ? 1'b0 : r_busy[addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wrEn && (addr == A3)) begin
      pending = 1'b0;
    end
`endif
    return pending;
  endfunction

  always_comb begin
    RD1   = readPort(A1);
    RD2   = readPort(A2);
    a0    = readPort(L_A0);
    ra    = readPort(L_RA);
    stall = busyOf(A1) | busyOf(A2);
  end

endmodule

// File: tb/tb_regfile_v2.sv
// Self-checking bench for regfile_v2: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_regfile_v2;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int DEP  = 32;
  localparam int TRIG = 5;
  localparam int A0I  = 10;
  localparam int RAI  = 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] A1, A2, A3, busy_addr;
  logic [DW-1:0] WD3;
  logic          WE3, trigger, busy_set;
  logic [DW-1:0] RD1, RD2, a0, ra;
  logic          stall;

  int checks = 0;
  int errors = 0;
  bit modelReady = 0;

  logic [DW-1:0] mReg [DEP];
  bit            mBusy [DEP];
  bit [3:1]      pinHist;

  regfile_v2 #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TRIG_REG(TRIG), .A0_REG(A0I), .RA_REG(RAI)
  ) dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .A3(A3), .WD3(WD3), .WE3(WE3), .trigger(trigger),
    .busy_set(busy_set), .busy_addr(busy_addr), .stall(stall), .a0(a0), .ra(ra)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic we, input logic [AW-1:0] a3, input logic [DW-1:0] wd,
                               input logic bs, input logic [AW-1:0] ba, input logic trig);
    A1 = a1; A2 = a2; WE3 = we; A3 = a3; WD3 = wd;
    busy_set = bs; busy_addr = ba; trigger = trig;
  endtask

  // Returns just after the next falling edge, so state reflects the preceding rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // The synchronised trigger at edge k equals the pin sampled two edges earlier;
  // a register set fires when that sample is 1 and the one before it was 0.
  function automatic bit edgeNow();
    return pinHist[2] && !pinHist[3];
  endfunction

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] addr);
    logic [DW-1:0] v;
    v = (addr == 0) ? '0 : mReg[addr];
`ifdef REGFILE_BYPASS_EN
    if (WE3 && A3 != 0 && A3 == addr) v = (edgeNow() && A3 == TRIG) ? 32'd1 : WD3;
`endif
    return v;
  endfunction

  function automatic logic modelBusy(input logic [AW-1:0] addr);
    logic b;
    b = (addr == 0) ? 1'b0 : logic'(mBusy[addr]);
`ifdef REGFILE_BYPASS_EN
    if (WE3 && A3 != 0 && A3 == addr) b = 1'b0;
`endif
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEP; i++) begin
        mReg[i] = '0;
        mBusy[i] = 1'b0;
      end
      pinHist = '0;
    end else begin
      bit fire;
      fire = edgeNow();
      if (WE3 && A3 != 0) begin
        mReg[A3] = WD3;
        mBusy[A3] = 1'b0;
      end
      if (fire) mReg[TRIG] = 32'd1;
      if (busy_set && busy_addr != 0) mBusy[busy_addr] = 1'b1;
      pinHist = {pinHist[2:1], trigger};
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("rd1", RD1, modelRead(A1));
      checkOutput("rd2", RD2, modelRead(A2));
      checkOutput("a0", a0, modelRead(AW'(A0I)));
      checkOutput("ra", ra, modelRead(AW'(RAI)));
      checkOutput("stall", {31'd0, stall}, {31'd0, modelBusy(A1) | modelBusy(A2)});
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    modelReady = 1;
    checkOutput("reset_rd1", RD1, 32'h0);
    checkOutput("reset_stall", {31'd0, stall}, 32'h0);
    rst = 1'b0;

    // Writes to register 0 are ignored.
    applyStimulus(0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_write", RD1, 32'h0);

    applyStimulus(10, 0, 1, 10, 32'h12345678, 0, 0, 0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_before_edge", RD1, 32'h12345678);
`else
    checkOutput("nobypass_before_edge", RD1, 32'h0);
`endif
    tick();
    applyStimulus(10, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd1_after_edge", RD1, 32'h12345678);
    checkOutput("a0_after_edge", a0, 32'h12345678);

    // Trigger held high: register 5 set three edges after the rise, not re-set after clearing.
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("trig_edge1", RD2, 32'h0);
    tick();
    checkOutput("trig_edge2", RD2, 32'h0);
    tick();
    checkOutput("trig_edge3", RD2, 32'h1);
    applyStimulus(0, 5, 1, 5, 32'h0, 0, 0, 1);
    tick();
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("trig_held_no_reset", RD2, 32'h0);

    // Trigger edge colliding with a software write of 0 to register 5.
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    applyStimulus(0, 5, 1, 5, 32'h0, 0, 0, 1);
    tick();
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("trig_wins", RD2, 32'h1);

    // Busy tracking and stall.
    applyStimulus(7, 0, 0, 0, 0, 1, 7, 0);
    tick();
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_set", {31'd0, stall}, 32'h1);
    applyStimulus(7, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("stall_write_cycle", {31'd0, stall}, 32'h0);
`else
    checkOutput("stall_write_cycle", {31'd0, stall}, 32'h1);
`endif
    tick();
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_cleared", {31'd0, stall}, 32'h0);
    applyStimulus(7, 0, 1, 7, 32'h1, 1, 7, 0);
    tick();
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_set_wins", {31'd0, stall}, 32'h1);

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 400; i++) begin
      logic t;
      t = trigger;
      if ($urandom_range(5) == 0) t = ~t;
      applyStimulus(AW'($urandom), AW'($urandom), logic'($urandom_range(1)),
                    ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom), $urandom,
                    ($urandom_range(3) == 0), AW'($urandom), t);
      tick();
    end

    // Asynchronous reset mid-cycle clears taps and stall before any clock edge.
    applyStimulus(1, 0, 1, 1, 32'hFFFFFFFF, 1, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ra_loaded", ra, 32'hFFFFFFFF);
    checkOutput("stall_loaded", {31'd0, stall}, 32'h1);
    applyStimulus(1, 0, 1, 1, 32'h55AA55AA, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ra", ra, 32'h0);
    checkOutput("async_rst_stall", {31'd0, stall}, 32'h0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    checkOutput("rst_discard_write", RD1, 32'h0);

    // Trigger held high through reset release yields exactly one set, three edges later.
    rst = 1'b0;
    tick();
    checkOutput("rst_trig_edge1", RD2, 32'h0);
    tick();
    checkOutput("rst_trig_edge2", RD2, 32'h0);
    tick();
    checkOutput("rst_trig_edge3", RD2, 32'h1);
    applyStimulus(1, 5, 1, 5, 32'h0, 0, 0, 1);
    tick();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rst_trig_no_dup", RD2, 32'h0);

    modelReady = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
